fnd_outport_display: RTL



---
 rtl/fnd_outport_display.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fnd_outport_display.sv
`timescale 1ns/1ps
// Shows the processor's 8-bit outport as up to three decimal digits on a 4-digit common-anode FND.
// A new value reaches the digit registers 10 clocks after in_q captures it, using sequential double-dabble.
// No backpressure: a value that changes mid-conversion is taken up when the FSM returns to idle.
module fnd_outport_display #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int SCAN_HZ  = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] outport,
   output logic [3:0] fnd_com,
   output logic [7:0] fnd_font,
   output logic       conv_busy
);

   localparam int TICK_DIV = CLK_FREQ / SCAN_HZ;
   localparam int CNT_W    = $clog2(TICK_DIV);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        in_q;
   logic [7:0]        last_val_q, last_val_d;
   logic [7:0]        src_q, src_d;
   logic [19:0]       sr_q, sr_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [3:0]        hund_q, hund_d;
   logic [3:0]        tens_q, tens_d;
   logic [3:0]        ones_q, ones_d;
   logic              busy_q, busy_d;
   logic [19:0]       sr_shift;

   logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic [1:0]        digit_sel_q, digit_sel_d;
   logic              tick;

   logic [3:0]        sel_digit;
   logic              sel_blank;

   // Add-3 correction applied to a BCD nibble before each shift.
   function automatic logic [3:0] bcd_adj(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

   // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp always off.
   function automatic logic [7:0] seg_of(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // One double-dabble iteration: correct every BCD nibble, then shift the whole register left.
   assign sr_shift = {bcd_adj(sr_q[19:16]), bcd_adj(sr_q[15:12]), bcd_adj(sr_q[11:8]), sr_q[7:0]} << 1;

   // Conversion FSM next-state and datapath.
   always_comb begin
      state_d    = state_q;
      last_val_d = last_val_q;
      src_d      = src_q;
      sr_d       = sr_q;
      bit_cnt_d  = bit_cnt_q;
      hund_d     = hund_q;
      tens_d     = tens_q;
      ones_d     = ones_q;
      case (state_q)
         ST_IDLE: begin
            if (in_q != last_val_q) begin
               sr_d      = {12'b0, in_q};
               src_d     = in_q;
               bit_cnt_d = 3'd0;
               state_d   = ST_CONV;
            end
         end
         ST_CONV: begin
            sr_d      = sr_shift;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            hund_d     = sr_q[19:16];
            tens_d     = sr_q[15:12];
            ones_d     = sr_q[11:8];
            last_val_d = src_q;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Busy covers the cycle after DONE too, so it spans entry into CONV through the digit update.
      busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
   end

   // Input capture plus conversion state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q       <= 8'd0;
         state_q    <= ST_IDLE;
         last_val_q <= 8'd0;
         src_q      <= 8'd0;
         sr_q       <= 20'd0;
         bit_cnt_q  <= 3'd0;
         hund_q     <= 4'd0;
         tens_q     <= 4'd0;
         ones_q     <= 4'd0;
         busy_q     <= 1'b0;
      end else begin
         in_q       <= outport;
         state_q    <= state_d;
         last_val_q <= last_val_d;
         src_q      <= src_d;
         sr_q       <= sr_d;
         bit_cnt_q  <= bit_cnt_d;
         hund_q     <= hund_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         busy_q     <= busy_d;
      end
   end

   assign conv_busy = busy_q;

   // Scan divider: tick at terminal count, digit select advances on each tick.
   always_comb begin
      tick        = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
      tick_cnt_d  = tick ? '0 : (tick_cnt_q + 1'b1);
      digit_sel_d = tick ? (digit_sel_q + 2'd1) : digit_sel_q;
   end

   // Scan registers run free, independent of the conversion FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_q  <= '0;
         digit_sel_q <= 2'd0;
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         digit_sel_q <= digit_sel_d;
      end
   end

   // Digit select, leading-zero blanking and segment decode.
   always_comb begin
      sel_digit = ones_q;
      sel_blank = 1'b0;
      fnd_com   = 4'b1110;
      case (digit_sel_q)
         2'd0: begin
            fnd_com   = 4'b1110;
            sel_digit = ones_q;
         end
         2'd1: begin
            fnd_com   = 4'b1101;
            sel_digit = tens_q;
            sel_blank = (hund_q == 4'd0) && (tens_q == 4'd0);
         end
         2'd2: begin
            fnd_com   = 4'b1011;
            sel_digit = hund_q;
            sel_blank = (hund_q == 4'd0);
         end
         default: begin
            fnd_com   = 4'b0111;
            sel_blank = 1'b1;
         end
      endcase
      fnd_font = sel_blank ? 8'hFF : seg_of(sel_digit);
   end

endmodule
